mem_responder: RTL

- Bus-side responder for the CPU controller's rd/wr strobes.
- Services 8-bit reads and writes to an internal RAM window on the 13-bit address bus.
- Inserts a programmable number of wait states and signals completion with ready.
- Drives read data with an explicit output-enable that the top level uses to control the shared data bus.

---
 rtl/mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Bus responder: 8-bit RAM window with WAIT programmable wait states; ready rises WAIT+1 cycles after strobe capture.
// No backpressure: ready/data are held until the controller drops its strobe, and a strobe drop during wait states aborts the access.
module mem_responder #(
  parameter int          WAIT     = 2,
  parameter int          RAM_AW   = 8,
  parameter logic [12:0] RAM_BASE = 13'h1800
) (
  input  logic        clk,
  input  logic        ena,
  input  logic        rd,
  input  logic        wr,
  input  logic [12:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {IDLE, WAITST, ACCESS, HOLD} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [12:0]       r_addr;
  logic [7:0]        r_wdat;
  logic              r_is_wr;
  logic [7:0]        r_ram [DEPTH];

  logic              w_strobe;
  logic              w_coll;
  logic              w_hit;
  logic [13:0]       w_addr_x;
  logic [13:0]       w_lo;
  logic [13:0]       w_hi;
  logic [RAM_AW-1:0] w_off;

  assign w_strobe = rd | wr;
  assign w_coll   = rd & wr;

  // Full-width compare on a zero-extended bus so the top of the window cannot wrap.
  assign w_addr_x = {1'b0, r_addr};
  assign w_lo     = {1'b0, RAM_BASE};
  assign w_hi     = w_lo + 14'(DEPTH);
  assign w_hit    = (w_addr_x >= w_lo) && (w_addr_x < w_hi);
  assign w_off    = RAM_AW'(r_addr - RAM_BASE);

  always_ff @(posedge clk or negedge ena) begin
    if (!ena) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_strobe && !w_coll) w_next = (WAIT == 0) ? ACCESS : WAITST;
      end
      WAITST: begin
        if (!w_strobe)        w_next = IDLE;
        else if (r_cnt == '0) w_next = ACCESS;
      end
      ACCESS: w_next = HOLD;
      HOLD: begin
        if (!w_strobe) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ena) begin
    if (!ena) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdat   <= '0;
      r_is_wr  <= 1'b0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_coll) begin
            err <= 1'b1;
          end else if (w_strobe) begin
            r_addr  <= addr;
            r_wdat  <= data_in;
            r_is_wr <= wr;
            r_cnt   <= (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
          end
        end
        WAITST: begin
          if (w_strobe && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
        end
        ACCESS: begin
          ready <= 1'b1;
          if (!r_is_wr) begin
            data_oe  <= 1'b1;
            data_out <= w_hit ? r_ram[w_off] : 8'h00;
          end
          if (!w_hit) err <= 1'b1;
        end
        HOLD: begin
          if (!w_strobe) begin
            ready    <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; a reset during the access forces IDLE, so no write can land.
  always_ff @(posedge clk) begin
    if (r_state == ACCESS && r_is_wr && w_hit) r_ram[w_off] <= r_wdat;
  end

endmodule
